datapath_sequencer: RTL and testbench

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

---
 rtl/datapath_seq_pkg.sv | 19 +
 rtl/dp_wait_counter.sv | 30 +++
 rtl/datapath_sequencer.sv | 133 +++++++++++++
 tb/tb_datapath_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared types and limits for the datapath sequencer.
// Holds the sequencer state enumeration, the default operand width and the
// largest supported datapath latency (which sizes the wait counter).
package datapath_seq_pkg;

    localparam int DEFAULT_DATAWIDTH = 32;
    localparam int MAX_LATENCY       = 15;
    localparam int WAIT_CNT_W        = $clog2(MAX_LATENCY + 1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_C = 3'd2,
        WAIT   = 3'd3,
        SEND_Z = 3'd4,
        SEND_X = 3'd5
    } seq_state_t;

endpackage

// File: rtl/dp_wait_counter.sv
// dp_wait_counter: loadable down-counter that times the external datapath.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; decrement saturates at zero so the flag stays up until the next load.
// Ports: clk, rst (sync, active-high), load + load_val, dec, zero.
module dp_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: collects operands a, b, c, waits LATENCY cycles for the datapath, then emits z, x.
// Latency: z is offered LATENCY cycles after c is accepted; x follows the cycle after z is taken.
// Backpressure: in_ready only in LOAD states; out_data/out_last held stable while out_valid && !out_ready.
// Ports: Clk, Rst (sync, active-high); in_valid/in_ready/in_data operand stream (a, b, c);
//        a, b, c registered operands to the datapath; z, x datapath results;
//        out_valid/out_ready/out_data/out_last result stream (z, then x with out_last);
//        busy high outside LOAD_A. Optional SEQ_TXN_COUNT_EN adds txn_count (accepted x words).
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int LATENCY   = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] z,
    input  logic [DATAWIDTH-1:0] x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
`ifdef SEQ_TXN_COUNT_EN
    ,
    output logic [15:0]          txn_count
`endif
);

    // The counter is loaded on the edge that enters WAIT, so LATENCY-1 more
    // decrements land the capture exactly LATENCY edges after c was taken.
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(LATENCY - 1);

    seq_state_t           state;
    seq_state_t           next_state;
    logic [DATAWIDTH-1:0] z_hold;
    logic [DATAWIDTH-1:0] x_hold;
    logic                 wait_load;
    logic                 wait_dec;
    logic                 wait_zero;
    logic                 capture;

    assign wait_load = (state == LOAD_C) && in_valid;
    assign wait_dec  = (state == WAIT);
    assign capture   = (state == WAIT) && wait_zero;

    dp_wait_counter #(
        .W(WAIT_CNT_W)
    ) u_wait_counter (
        .clk      (Clk),
        .rst      (Rst),
        .load     (wait_load),
        .load_val (WAIT_INIT),
        .dec      (wait_dec),
        .zero     (wait_zero)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= LOAD_A;
            a      <= '0;
            b      <= '0;
            c      <= '0;
            z_hold <= '0;
            x_hold <= '0;
        end else begin
            state <= next_state;
            if (in_valid && (state == LOAD_A)) a <= in_data;
            if (in_valid && (state == LOAD_B)) b <= in_data;
            if (in_valid && (state == LOAD_C)) c <= in_data;
            // Results are snapshotted so later datapath activity cannot disturb a stalled word.
            if (capture) begin
                z_hold <= z;
                x_hold <= x;
            end
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        unique case (state)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) next_state = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) next_state = LOAD_C;
            end
            LOAD_C: begin
                in_ready = 1'b1;
                if (in_valid) next_state = WAIT;
            end
            WAIT: begin
                if (wait_zero) next_state = SEND_Z;
            end
            SEND_Z: begin
                out_valid = 1'b1;
                out_data  = z_hold;
                if (out_ready) next_state = SEND_X;
            end
            SEND_X: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = x_hold;
                if (out_ready) next_state = LOAD_A;
            end
            default: next_state = LOAD_A;
        endcase
    end

    assign busy = (state != LOAD_A);

`ifdef SEQ_TXN_COUNT_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            txn_count <= '0;
        end else if ((state == SEND_X) && out_ready) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: bench for datapath_sequencer at LATENCY=1 and LATENCY=4.
// Both instances share stimulus; sel routes in_valid to one and picks its outputs for checking.
// Datapath stub: z=a+b+c, x=a-b, valid for the sequencer's sampling edge LATENCY edges after c loads.
module tb_datapath_sequencer;

    localparam int W = 32;

    logic         Clk       = 1'b0;
    logic         Rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         out_ready = 1'b0;
    logic         sel       = 1'b0;
    logic [W-1:0] zx_jam    = '0;
    int           cyc       = 0;
    int           n_checks  = 0;
    int           n_pass    = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    logic in_valid1, in_valid4;
    assign in_valid1 = in_valid & ~sel;
    assign in_valid4 = in_valid & sel;

    logic         in_ready1, out_valid1, out_last1, busy1;
    logic [W-1:0] a1, b1, c1, z1, x1, out_data1;
    logic         in_ready4, out_valid4, out_last4, busy4;
    logic [W-1:0] a4, b4, c4, z4, x4, out_data4;
`ifdef SEQ_TXN_COUNT_EN
    logic [15:0]  txn_count1, txn_count4;
`endif

    datapath_sequencer #(.DATAWIDTH(W), .LATENCY(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
        .a(a1), .b(b1), .c(c1), .z(z1), .x(x1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1)
`ifdef SEQ_TXN_COUNT_EN
        , .txn_count(txn_count1)
`endif
    );

    datapath_sequencer #(.DATAWIDTH(W), .LATENCY(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data),
        .a(a4), .b(b4), .c(c4), .z(z4), .x(x4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_last(out_last4), .busy(busy4)
`ifdef SEQ_TXN_COUNT_EN
        , .txn_count(txn_count4)
`endif
    );

    // LATENCY=1: result settles within the cycle after c loads.
    assign z1 = (a1 + b1 + c1) ^ zx_jam;
    assign x1 = (a1 - b1) ^ zx_jam;

    // LATENCY=4: three register stages ahead of the sampling edge.
    logic [W-1:0] zp [3];
    logic [W-1:0] xp [3];
    always @(posedge Clk) begin
        zp[0] <= a4 + b4 + c4;
        xp[0] <= a4 - b4;
        zp[1] <= zp[0];
        xp[1] <= xp[0];
        zp[2] <= zp[1];
        xp[2] <= xp[1];
    end
    assign z4 = zp[2] ^ zx_jam;
    assign x4 = xp[2] ^ zx_jam;

    logic         o_in_ready, o_out_valid, o_out_last, o_busy;
    logic [W-1:0] o_out_data, o_a, o_b, o_c;
    assign o_in_ready  = sel ? in_ready4  : in_ready1;
    assign o_out_valid = sel ? out_valid4 : out_valid1;
    assign o_out_last  = sel ? out_last4  : out_last1;
    assign o_busy      = sel ? busy4      : busy1;
    assign o_out_data  = sel ? out_data4  : out_data1;
    assign o_a         = sel ? a4 : a1;
    assign o_b         = sel ? b4 : b1;
    assign o_c         = sel ? c4 : c1;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!o_in_ready && t < 100) begin
            step();
            t++;
        end
        if (!o_in_ready) begin
            n_checks++;
            $display("FAIL send_word_timeout: in_ready=%0b required 1 within 100 cycles", o_in_ready);
        end else begin
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int budget);
        int t = 0;
        while (!o_out_valid && t < budget) begin
            step();
            t++;
        end
        if (!o_out_valid) begin
            n_checks++;
            $display("FAIL wait_out_valid_timeout: out_valid=%0b required 1 within %0d cycles", o_out_valid, budget);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        Rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if ({in_ready1, out_valid1, out_last1, busy1} !== 4'b1000)
            $display("FAIL reset_ctl_l1: rdy/vld/last/busy=%b required 1000", {in_ready1, out_valid1, out_last1, busy1});
        else n_pass++;
        n_checks++;
        if ({in_ready4, out_valid4, out_last4, busy4} !== 4'b1000)
            $display("FAIL reset_ctl_l4: rdy/vld/last/busy=%b required 1000", {in_ready4, out_valid4, out_last4, busy4});
        else n_pass++;
        n_checks++;
        if ({out_data1, out_data4} !== 64'd0)
            $display("FAIL reset_out_data: got %h/%h required 0/0", out_data1, out_data4);
        else n_pass++;
        n_checks++;
        if ({a1, b1, c1, a4, b4, c4} !== '0)
            $display("FAIL reset_operands: a1=%h b1=%h c1=%h a4=%h b4=%h c4=%h required all 0", a1, b1, c1, a4, b4, c4);
        else n_pass++;
        Rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        int t_first;
        sel = 1'b0; out_ready = 1'b1;
        send_word(32'd5);
        t_first = cyc;
        send_word(32'd3);
        send_word(32'd7);
        n_checks++;
        if ({o_a, o_b, o_c, o_busy} !== {32'd5, 32'd3, 32'd7, 1'b1})
            $display("FAIL basic_operands: a=%0d b=%0d c=%0d busy=%0b required 5 3 7 1", o_a, o_b, o_c, o_busy);
        else n_pass++;
        wait_out_valid(20);
        // three loads then one wait cycle
        n_checks++;
        if (cyc - t_first !== 3)
            $display("FAIL basic_z_timing: z offered %0d cycles after first accept, required 3", cyc - t_first);
        else n_pass++;
        n_checks++;
        if ({o_out_valid, o_out_data, o_out_last} !== {1'b1, 32'd15, 1'b0})
            $display("FAIL basic_z: vld=%0b data=%0d last=%0b required 1 15 0", o_out_valid, o_out_data, o_out_last);
        else n_pass++;
        step();
        n_checks++;
        if ({o_out_valid, o_out_data, o_out_last} !== {1'b1, 32'd2, 1'b1})
            $display("FAIL basic_x: vld=%0b data=%0d last=%0b required 1 2 1", o_out_valid, o_out_data, o_out_last);
        else n_pass++;
        step();
        // x taken on the 6th edge counting the first accept as edge 0; next a lands one edge later
        n_checks++;
        if ({cyc - t_first, o_in_ready, o_out_valid, o_busy} !== {32'd5, 1'b1, 1'b0, 1'b0})
            $display("FAIL basic_period: edges=%0d rdy=%0b vld=%0b busy=%0b required 5 1 0 0",
                     cyc - t_first, o_in_ready, o_out_valid, o_busy);
        else n_pass++;
    endtask

    task automatic test_stall();
        sel = 1'b0; out_ready = 1'b0;
        send_word(32'd5);
        send_word(32'd3);
        send_word(32'd7);
        wait_out_valid(20);
        zx_jam = $urandom | 32'h1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({o_out_valid, o_out_data, o_out_last} !== {1'b1, 32'd15, 1'b0})
                $display("FAIL stall_hold_%0d: vld=%0b data=%0d last=%0b required 1 15 0", i, o_out_valid, o_out_data, o_out_last);
            else n_pass++;
            step();
        end
        n_checks++;
        if ({o_out_valid, o_out_data, o_out_last} !== {1'b1, 32'd15, 1'b0})
            $display("FAIL stall_end: vld=%0b data=%0d last=%0b required 1 15 0", o_out_valid, o_out_data, o_out_last);
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_checks++;
        if ({o_out_valid, o_out_data, o_out_last} !== {1'b1, 32'd2, 1'b1})
            $display("FAIL stall_x: vld=%0b data=%0d last=%0b required 1 2 1", o_out_valid, o_out_data, o_out_last);
        else n_pass++;
        step();
        zx_jam = '0;
        n_checks++;
        if (o_out_valid !== 1'b0)
            $display("FAIL stall_done: out_valid=%0b required 0", o_out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        sel = 1'b0; out_ready = 1'b1;
        send_word(32'd10);
        send_word(32'd20);
        // reset coincides with an offered word; the word must be dropped
        in_valid = 1'b1; in_data = 32'd99; Rst = 1'b1;
        step();
        Rst = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({o_in_ready, o_busy, o_a, o_b} !== {1'b1, 1'b0, 64'd0})
            $display("FAIL rstmid_state: rdy=%0b busy=%0b a=%0d b=%0d required 1 0 0 0", o_in_ready, o_busy, o_a, o_b);
        else n_pass++;
        send_word(32'd1);
        send_word(32'd2);
        send_word(32'd3);
        wait_out_valid(20);
        n_checks++;
        if ({o_out_data, o_out_last} !== {32'd6, 1'b0})
            $display("FAIL rstmid_z: data=%h last=%0b required 00000006 0", o_out_data, o_out_last);
        else n_pass++;
        step();
        n_checks++;
        if ({o_out_valid, o_out_data, o_out_last} !== {1'b1, 32'hFFFF_FFFF, 1'b1})
            $display("FAIL rstmid_x: vld=%0b data=%h last=%0b required 1 ffffffff 1", o_out_valid, o_out_data, o_out_last);
        else n_pass++;
        step();
        // reset while z is stalled: pending results are abandoned
        out_ready = 1'b0;
        send_word(32'd4);
        send_word(32'd5);
        send_word(32'd6);
        wait_out_valid(20);
        Rst = 1'b1;
        step();
        Rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (o_out_valid) seen++;
            step();
        end
        n_checks++;
        if ({seen, o_busy} !== {32'd0, 1'b0})
            $display("FAIL rstmid_stalled: valid cycles=%0d busy=%0b required 0 0", seen, o_busy);
        else n_pass++;
    endtask

    task automatic test_latency4();
        int t_wait;
        sel = 1'b1; out_ready = 1'b1;
        send_word(32'hFFFF_FFFF);
        send_word(32'd1);
        send_word(32'd0);
        t_wait = cyc;
        wait_out_valid(30);
        n_checks++;
        if (cyc - t_wait !== 4)
            $display("FAIL lat4_timing: out_valid %0d cycles after WAIT entry, required 4", cyc - t_wait);
        else n_pass++;
        n_checks++;
        if ({o_out_data, o_out_last} !== {32'd0, 1'b0})
            $display("FAIL lat4_z: data=%h last=%0b required 00000000 0", o_out_data, o_out_last);
        else n_pass++;
        step();
        n_checks++;
        if ({o_out_valid, o_out_data, o_out_last} !== {1'b1, 32'hFFFF_FFFE, 1'b1})
            $display("FAIL lat4_x: vld=%0b data=%h last=%0b required 1 fffffffe 1", o_out_valid, o_out_data, o_out_last);
        else n_pass++;
        step();
    endtask

    task automatic test_random(input logic s, input int n_trip);
        logic [W-1:0] exp_d[$];
        logic         exp_l[$];
        int           got = 0;
`ifdef SEQ_TXN_COUNT_EN
        logic [15:0]  tc0;
        tc0 = s ? txn_count4 : txn_count1;
`endif
        sel = s; out_ready = 1'b0;
        fork
            begin : drv
                for (int i = 0; i < n_trip; i++) begin
                    logic [W-1:0] ra, rb, rc;
                    ra = pick();
                    rb = pick();
                    rc = pick();
                    exp_d.push_back(ra + rb + rc);
                    exp_l.push_back(1'b0);
                    exp_d.push_back(ra - rb);
                    exp_l.push_back(1'b1);
                    repeat ($urandom_range(0, 2)) step();
                    send_word(ra);
                    repeat ($urandom_range(0, 2)) step();
                    send_word(rb);
                    repeat ($urandom_range(0, 2)) step();
                    send_word(rc);
                end
            end
            begin : mon
                int           budget = 0;
                logic         pend = 1'b0;
                logic [W-1:0] pd = '0;
                logic         pl = 1'b0;
                logic [W-1:0] ed;
                logic         el;
                while (got < 2 * n_trip && budget < 5000) begin
                    @(negedge Clk);
                    budget++;
                    if (pend) begin
                        n_checks++;
                        if ({o_out_valid, o_out_data, o_out_last} !== {1'b1, pd, pl})
                            $display("FAIL rand_stable: vld=%0b data=%h last=%0b required 1 %h %0b",
                                     o_out_valid, o_out_data, o_out_last, pd, pl);
                        else n_pass++;
                    end
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (o_out_valid && out_ready) begin
                        if (exp_d.size() == 0) begin
                            n_checks++;
                            $display("FAIL rand_extra: unexpected word data=%h last=%0b", o_out_data, o_out_last);
                        end else begin
                            ed = exp_d.pop_front();
                            el = exp_l.pop_front();
                            n_checks++;
                            if ({o_out_data, o_out_last} !== {ed, el})
                                $display("FAIL rand_word_%0d: data=%h last=%0b required %h %0b", got, o_out_data, o_out_last, ed, el);
                            else n_pass++;
                        end
                        got++;
                        pend = 1'b0;
                    end else begin
                        pend = o_out_valid;
                        pd   = o_out_data;
                        pl   = o_out_last;
                    end
                end
            end
        join
        step();
        out_ready = 1'b1;
        n_checks++;
        if (got !== 2 * n_trip)
            $display("FAIL rand_count: received %0d words required %0d", got, 2 * n_trip);
        else n_pass++;
`ifdef SEQ_TXN_COUNT_EN
        n_checks++;
        if ((s ? txn_count4 : txn_count1) !== 16'(tc0 + 16'(n_trip)))
            $display("FAIL rand_txn_count: got %0d required %0d", s ? txn_count4 : txn_count1, 16'(tc0 + 16'(n_trip)));
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_latency4();
        test_random(1'b0, 40);
        test_random(1'b1, 40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
